instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's per-cycle instruction reads. It sits between the PC register and the backing instruction memory. A hit returns the instruction combinationally in the same cycle. A miss raises `stall`, which the pipeline uses as the fetch freeze, while a four-word line is filled over a req/ready memory interface.

---
 rtl/instruction_cache_if.sv | 22 ++
 rtl/instruction_cache.sv | 100 ++++++++++
 tb/tb_instruction_cache.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-side and backing-memory signals of the instruction cache, bundled for port connection.
// The cache takes the slave view; the fetch stage / memory environment takes the master view.
interface instruction_cache_if;
    logic [31:0] address;
    logic        flush;
    logic [31:0] instruction;
    logic        stall;
    logic        memReq;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memData;

    modport slave (
        input  address, flush, memReady, memData,
        output instruction, stall, memReq, memAddress
    );

    modport master (
        output address, flush, memReady, memData,
        input  instruction, stall, memReq, memAddress
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, four-beat line
// fill over a req/ready memory port, stall drives the fetch freeze.
module instruction_cache #(
    parameter int LINES = 64
) (
    input logic                 clk,
    input logic                 rst,
    instruction_cache_if.slave  bus
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]    state;
    logic [1:0]    beat;
    logic [27:0]   fill_line;
    logic          flushed;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tag_mem  [LINES];
    logic [31:0]   data_mem [LINES*4];

    logic [1:0]    req_off;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] fill_idx;
    logic          hit;
    logic          unused_addr_bits;

    assign req_off  = bus.address[3:2];
    assign req_idx  = bus.address[3+IW:4];
    assign req_tag  = bus.address[31:4+IW];
    assign fill_idx = fill_line[IW-1:0];
    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_addr_bits = ^bus.address[1:0];

    always_comb begin
        bus.stall       = 1'b1;
        bus.instruction = '0;
        bus.memReq      = 1'b0;
        bus.memAddress  = '0;
        if (state == IDLE) begin
            if (hit) begin
                bus.stall       = 1'b0;
                bus.instruction = data_mem[{req_idx, req_off}];
            end
        end else begin
            // beat is 2 bits, so the beat address wraps inside the line
            bus.memReq     = 1'b1;
            bus.memAddress = {fill_line, beat, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            beat      <= 2'd0;
            flushed   <= 1'b0;
            fill_line <= '0;
        end else begin
            if (bus.flush)
                valid <= '0;
            case (state)
                IDLE: begin
                    if (!hit) begin
                        fill_line <= bus.address[31:4];
                        beat      <= 2'd0;
                        flushed   <= 1'b0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush)
                        flushed <= 1'b1;
                    if (bus.memReady) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            state   <= IDLE;
                            flushed <= 1'b0;
                            // a flush on the final beat also keeps the line invalid
                            if (!flushed && !bus.flush)
                                valid[fill_idx] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == FILL && bus.memReady) begin
            data_mem[{fill_idx, beat}] <= bus.memData;
            if (beat == 2'd3)
                tag_mem[fill_idx] <= fill_line[27:IW];
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: scenario tasks against a line-level
// reference model (valid/tag table plus an arithmetic backing memory).
module tb_instruction_cache;
    localparam int LINES = 64;
    localparam int IW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bit          mv [LINES];
    logic [31:0] mt [LINES];

    instruction_cache_if bus ();

    instruction_cache #(.LINES(LINES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    assign bus.memData = bus.memReady ? memfn(bus.memAddress) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned idx;
        idx = (a >> 4) % LINES;
        return mv[idx] && (mt[idx] == (a >> (4 + IW)));
    endfunction

    // One fetch of address a. period=0 gives random memReady, otherwise ready on every
    // period-th fill cycle. sw_beat/fl_beat >= 0 switch address / pulse flush at that beat.
    task automatic do_fetch(input logic [31:0] a, input int period, input int sw_beat,
                            input logic [31:0] alt, input int fl_beat, input string name);
        int beats, k;
        bit fdone, fl;
        logic [31:0] line;
        bus.address = a; bus.flush = 1'b0; bus.memReady = 1'b0;
        #1;
        if (model_hit(a)) begin
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL %s hit stall: got %b want 0", name, bus.stall); end
            checks++; if (bus.instruction !== memfn({a[31:2], 2'b00})) begin errors++; $display("FAIL %s hit instruction: got %h want %h", name, bus.instruction, memfn({a[31:2], 2'b00})); end
            checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL %s hit memReq: got %b want 0", name, bus.memReq); end
            tick();
            return;
        end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL %s miss stall: got %b want 1", name, bus.stall); end
        checks++; if (bus.instruction !== 32'd0) begin errors++; $display("FAIL %s miss instruction: got %h want 0", name, bus.instruction); end
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL %s miss-cycle memReq: got %b want 0", name, bus.memReq); end
        tick();
        line = {a[31:4], 4'b0000};
        beats = 0; k = 0; fdone = 0; fl = 0;
        while (beats < 4) begin
            if (k >= 100) begin
                errors++; checks++;
                $display("FAIL %s fill timeout: got %0d beats want 4", name, beats);
                break;
            end
            if (sw_beat >= 0 && beats == sw_beat) bus.address = alt;
            if (fl_beat >= 0 && beats == fl_beat && !fdone) begin
                bus.flush = 1'b1; fdone = 1; fl = 1; model_clear();
            end else begin
                bus.flush = 1'b0;
            end
            bus.memReady = (period == 0) ? 1'($urandom_range(0, 1)) : ((k % period) == period - 1);
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL %s fill stall: got %b want 1", name, bus.stall); end
            checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL %s fill memReq: got %b want 1", name, bus.memReq); end
            checks++; if (bus.memAddress !== line + 32'(4 * beats)) begin errors++; $display("FAIL %s fill memAddress: got %h want %h", name, bus.memAddress, line + 32'(4 * beats)); end
            checks++; if (bus.instruction !== 32'd0) begin errors++; $display("FAIL %s fill instruction: got %h want 0", name, bus.instruction); end
            if (bus.memReady) beats++;
            k++;
            tick();
        end
        bus.memReady = 1'b0; bus.flush = 1'b0;
        if (!fl) begin
            mv[(a >> 4) % LINES] = 1'b1;
            mt[(a >> 4) % LINES] = a >> (4 + IW);
        end
    endtask

    task automatic test_reset();
        model_clear();
        rst = 1'b0; bus.address = $urandom; bus.flush = 1'b0; bus.memReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL reset memReq: got %b want 0", bus.memReq); end
            checks++; if (bus.memAddress !== 32'd0) begin errors++; $display("FAIL reset memAddress: got %h want 0", bus.memAddress); end
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset stall: got %b want 1", bus.stall); end
            checks++; if (bus.instruction !== 32'd0) begin errors++; $display("FAIL reset instruction: got %h want 0", bus.instruction); end
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL post-reset stall: got %b want 1", bus.stall); end
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h0, 1, -1, 32'h0, -1, "cold_fill");
        do_fetch(32'h0, 1, -1, 32'h0, -1, "cold_hit0");
        do_fetch(32'h4, 1, -1, 32'h0, -1, "cold_hit4");
        do_fetch(32'h8, 1, -1, 32'h0, -1, "cold_hit8");
        do_fetch(32'hC, 1, -1, 32'h0, -1, "cold_hitC");
    endtask

    task automatic test_conflict();
        do_fetch(32'h400, 1, -1, 32'h0, -1, "conflict_fill400");
        do_fetch(32'h408, 1, -1, 32'h0, -1, "conflict_hit408");
        do_fetch(32'h000, 1, -1, 32'h0, -1, "conflict_refill000");
        do_fetch(32'h004, 1, -1, 32'h0, -1, "conflict_hit004");
    endtask

    task automatic test_slow_memory();
        logic [31:0] a, prev;
        int stalls, accepts, fk;
        bit have_prev, last_acc;
        a = 32'h3000; stalls = 0; accepts = 0; fk = 0; have_prev = 0; last_acc = 0;
        bus.address = a; bus.flush = 1'b0; bus.memReady = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bus.memReady = 1'b0;
            #1;
            if (bus.stall === 1'b0) break;
            stalls++;
            if (bus.memReq === 1'b1) begin
                if (have_prev && !last_acc) begin
                    checks++; if (bus.memAddress !== prev) begin errors++; $display("FAIL slow addr_stable: got %h want %h", bus.memAddress, prev); end
                end
                bus.memReady = ((fk % 3) == 2);
                last_acc = bus.memReady;
                if (bus.memReady) begin
                    checks++; if (bus.memAddress !== a + 32'(4 * accepts)) begin errors++; $display("FAIL slow beat_addr: got %h want %h", bus.memAddress, a + 32'(4 * accepts)); end
                    accepts++;
                end
                prev = bus.memAddress; have_prev = 1; fk++;
            end
            tick();
        end
        bus.memReady = 1'b0;
        checks++; if (stalls != 13) begin errors++; $display("FAIL slow stall_cycles: got %0d want 13", stalls); end
        checks++; if (accepts != 4) begin errors++; $display("FAIL slow beats: got %0d want 4", accepts); end
        checks++; if (bus.instruction !== memfn(a)) begin errors++; $display("FAIL slow hit_instruction: got %h want %h", bus.instruction, memfn(a)); end
        tick();
        mv[(a >> 4) % LINES] = 1'b1; mt[(a >> 4) % LINES] = a >> (4 + IW);
        do_fetch(32'h300C, 1, -1, 32'h0, -1, "slow_hit300C");
    endtask

    task automatic test_address_change();
        do_fetch(32'h20, 1, 1, 32'h100, -1, "switch_fill20");
        do_fetch(32'h100, 1, -1, 32'h0, -1, "switch_fill100");
        do_fetch(32'h24, 1, -1, 32'h0, -1, "switch_hit24");
        do_fetch(32'h104, 1, -1, 32'h0, -1, "switch_hit104");
    endtask

    task automatic test_flush();
        do_fetch(32'h40, 1, -1, 32'h0, 1, "flushA_fill40");
        do_fetch(32'h40, 1, -1, 32'h0, -1, "flushA_refill40");
        do_fetch(32'h44, 1, -1, 32'h0, -1, "flushA_hit44");
        bus.address = 32'h48; bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flushB same-cycle stall: got %b want 0", bus.stall); end
        checks++; if (bus.instruction !== memfn(32'h48)) begin errors++; $display("FAIL flushB same-cycle instruction: got %h want %h", bus.instruction, memfn(32'h48)); end
        tick();
        bus.flush = 1'b0;
        model_clear();
        do_fetch(32'h48, 1, -1, 32'h0, -1, "flushB_refill48");
    endtask

    task automatic test_reset_mid_fill();
        do_fetch(32'h44, 1, -1, 32'h0, -1, "rstfill_hit44");
        bus.address = 32'h500; bus.memReady = 1'b0;
        tick();
        bus.memReady = 1'b1;
        tick();
        tick();
        checks++; if (bus.memAddress !== 32'h508) begin errors++; $display("FAIL rstfill beat2 memAddress: got %h want 00000508", bus.memAddress); end
        rst = 1'b0;
        tick();
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL rstfill memReq: got %b want 0", bus.memReq); end
        checks++; if (bus.memAddress !== 32'd0) begin errors++; $display("FAIL rstfill memAddress: got %h want 0", bus.memAddress); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstfill stall: got %b want 1", bus.stall); end
        rst = 1'b1; bus.memReady = 1'b0;
        model_clear();
        do_fetch(32'h44, 1, -1, 32'h0, -1, "rstfill_miss44");
        do_fetch(32'h500, 1, -1, 32'h0, -1, "rstfill_fill500");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int fb;
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_fetch(a, 0, -1, 32'h0, fb, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_slow_memory();
        test_address_change();
        test_flush();
        test_reset_mid_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
